// File: rtl/pwm_led_pkg.sv
// ---------------------------------------------------------------------------
// pwm_led_pkg
//
// Purpose:
//   Shared definitions for the multi-channel LED PWM driver:
//   - default parameter values for the top level;
//   - a helper that sizes channel-index and prescaler fields.
//
// Contents:
//   DEF_CH, DEF_WIDTH, DEF_PRESCALE : default CH / WIDTH / PRESCALE
//   idx_width(n)                    : $clog2(n), never less than 1, so a
//                                     one-entry index still has a real bit
// ---------------------------------------------------------------------------
package pwm_led_pkg;

    localparam int DEF_CH       = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_PRESCALE = 1;

    // Bits needed to index n items, with a floor of 1 so that ports and
    // registers never collapse to zero width when n is 1 or 2.
    function automatic int idx_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage : pwm_led_pkg

// File: rtl/pwm_led_channel.sv
// ---------------------------------------------------------------------------
// pwm_led_channel
//
// Purpose:
//   One PWM channel. It holds a double-buffered duty value and a registered
//   compare output.
//   - Software writes land in the shadow register at any time.
//   - The active register only changes on the period wrap, so a duty change
//     can never cut a period short or stretch it (no glitches).
//
// Build option:
//   PWM_LED_FADE_EN
//     defined   : at each wrap the active duty steps one LSB toward shadow
//                 (linear fade, no overshoot, no wrap-around).
//     undefined : at each wrap the active duty loads shadow directly.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-high reset
//   wr_en    in   single-cycle write strobe for this channel's shadow duty
//   wr_data  in   WIDTH  new duty value
//   wrap     in   high on the clk whose edge takes the counter to 0
//   counter  in   WIDTH  shared period counter
//   led      out  registered PWM output: counter < active duty
// ---------------------------------------------------------------------------
module pwm_led_channel
    import pwm_led_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wrap,
    input  logic [WIDTH-1:0] counter,
    output logic             led
);

    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_active;
    logic             r_led;
    logic [WIDTH-1:0] w_active_next;

`ifdef PWM_LED_FADE_EN
    // Step one LSB toward the target. The comparisons guarantee the step
    // never crosses the target, and never leaves 0..2**WIDTH-1.
    always_comb begin
        w_active_next = r_active;
        if (r_active < r_shadow) begin
            w_active_next = r_active + WIDTH'(1);
        end else if (r_active > r_shadow) begin
            w_active_next = r_active - WIDTH'(1);
        end
    end
`else
    assign w_active_next = r_shadow;
`endif

    // Shadow: the last write wins. wr_en is a strobe that is always
    // accepted, with no back-pressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow <= '0;
        end else if (wr_en) begin
            r_shadow <= wr_data;
        end
    end

    // Active: this register reads r_shadow before any write on the same edge
    // updates it. So a write that coincides with a wrap takes effect one
    // period later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active <= '0;
        end else if (wrap) begin
            r_active <= w_active_next;
        end
    end

    // The compare is registered, so led lags the counter by one clk.
    // A duty of 2**WIDTH-1 still leaves one low step per period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led <= 1'b0;
        end else begin
            r_led <= (counter < r_active);
        end
    end

    assign led = r_led;

endmodule : pwm_led_channel

// File: rtl/pwm_led_multi.sv
// ---------------------------------------------------------------------------
// pwm_led_multi
//
// Purpose:
//   CH-channel LED PWM driver.
//   - All channels share one period counter and one programmable prescaler.
//   - A period is 2**WIDTH counter steps of PRESCALE clk each.
//   - Each channel has its own double-buffered duty register, so software
//     may rewrite duties at any time without glitching the LED pins.
//
// Build option:
//   PWM_LED_FADE_EN - when defined, each channel ramps its active duty one
//   LSB per period toward the written value instead of jumping to it.
//
// Parameters:
//   CH        number of channels (1..16)
//   WIDTH     duty / counter resolution in bits
//   PRESCALE  clk cycles per counter step (>= 1)
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   duty_wr_en    in   single-cycle shadow-duty write strobe; always
//                      accepted, no back-pressure
//   duty_wr_ch    in   idx_width(CH)  target channel; indices >= CH are
//                      ignored
//   duty_wr_data  in   WIDTH  new duty value
//   period_start  out  one-clk pulse on the clk where the counter becomes 0
//   led           out  CH  registered PWM outputs
// ---------------------------------------------------------------------------
module pwm_led_multi
    import pwm_led_pkg::*;
#(
    parameter int CH       = DEF_CH,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     duty_wr_en,
    input  logic [idx_width(CH)-1:0] duty_wr_ch,
    input  logic [WIDTH-1:0]         duty_wr_data,
    output logic                     period_start,
    output logic [CH-1:0]            led
);

    localparam int                CH_W    = idx_width(CH);
    localparam int                PS_W    = idx_width(PRESCALE);
    localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0]  CNT_MAX = '1;

    logic [PS_W-1:0]  r_prescale;
    logic [WIDTH-1:0] r_counter;
    logic             r_period_start;
    logic             w_tick;
    logic             w_wrap;

    // ---------------------------------------------------------------------
    // Prescaler: counts 0..PRESCALE-1 and produces one tick per counter
    // step. With PRESCALE=1 it stays at 0 and ticks on every clk.
    // ---------------------------------------------------------------------
    assign w_tick = (r_prescale == PS_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prescale <= '0;
        end else if (w_tick) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + PS_W'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Period counter: wraps naturally from all-ones to zero.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_counter <= '0;
        end else if (w_tick) begin
            r_counter <= r_counter + WIDTH'(1);
        end
    end

    // wrap marks the edge that takes the counter back to 0. Registering it
    // makes period_start high on the clk where the counter reads 0.
    assign w_wrap = w_tick && (r_counter == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= w_wrap;
        end
    end

    assign period_start = r_period_start;

    // ---------------------------------------------------------------------
    // Channels. Each one matches only its own index, so an out-of-range
    // duty_wr_ch selects no channel and the write is dropped.
    // ---------------------------------------------------------------------
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        logic w_sel;

        assign w_sel = duty_wr_en && (duty_wr_ch == CH_W'(gi));

        pwm_led_channel #(
            .WIDTH (WIDTH)
        ) u_channel (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (w_sel),
            .wr_data (duty_wr_data),
            .wrap    (w_wrap),
            .counter (r_counter),
            .led     (led[gi])
        );
    end

endmodule : pwm_led_multi
